// File: rtl/aes_word_loader.sv
// aes_word_loader: word-serial front/back end for a combinational AES-128 core.
// Assembles key and data blocks from 32-bit words (MSW first), holds them stable
// for LATENCY_CYCLES, captures the core result and streams it out as four words.
module aes_word_loader #(
    parameter int unsigned LATENCY_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         InValid,
    output logic         InReady,
    input  logic [31:0]  InData,
    input  logic         InIsKey,
    input  logic         InInv,
    output logic [127:0] BlkInput,
    output logic [127:0] BlkKey,
    output logic         BlkInv,
    input  logic [127:0] BlkOutput,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [31:0]  OutData,
    output logic         OutLast,
    output logic         Busy
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LAST = 4'(LATENCY_CYCLES - 1);

    state_t       state_q,     state_d;
    logic [2:0]   data_cnt_q,  data_cnt_d;
    logic [1:0]   key_cnt_q,   key_cnt_d;
    logic         key_valid_q, key_valid_d;
    logic [3:0]   wait_cnt_q,  wait_cnt_d;
    logic [1:0]   out_cnt_q,   out_cnt_d;
    logic [127:0] blk_input_q, blk_input_d;
    logic [127:0] blk_key_q,   blk_key_d;
    logic         blk_inv_q,   blk_inv_d;
    logic [127:0] result_q,    result_d;

    logic         in_ready;
    logic         in_fire;
    // Slot n of a 128-bit block starts at bit 32*(3-n); for a 2-bit n that is {~n, 5'b0}.
    logic [6:0]   data_base;
    logic [6:0]   key_base;
    logic [6:0]   out_base;

    // Key words are always accepted in LOAD; a 5th data word is stalled.
    assign in_ready  = (state_q == ST_LOAD) && !((data_cnt_q == 3'd4) && !InIsKey);
    assign in_fire   = InValid && in_ready;
    assign data_base = {~data_cnt_q[1:0], 5'd0};
    assign key_base  = {~key_cnt_q, 5'd0};
    assign out_base  = {~out_cnt_q, 5'd0};

    assign InReady  = in_ready;
    assign BlkInput = blk_input_q;
    assign BlkKey   = blk_key_q;
    assign BlkInv   = blk_inv_q;
    assign Busy     = (state_q != ST_LOAD);

    // Next-state, word assembly, wait counting and output streaming.
    always_comb begin
        state_d     = state_q;
        data_cnt_d  = data_cnt_q;
        key_cnt_d   = key_cnt_q;
        key_valid_d = key_valid_q;
        wait_cnt_d  = wait_cnt_q;
        out_cnt_d   = out_cnt_q;
        blk_input_d = blk_input_q;
        blk_key_d   = blk_key_q;
        blk_inv_d   = blk_inv_q;
        result_d    = result_q;
        OutValid    = 1'b0;
        OutData     = '0;
        OutLast     = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                if (in_fire) begin
                    if (InIsKey) begin
                        blk_key_d[key_base +: 32] = InData;
                        key_cnt_d = key_cnt_q + 2'd1;
                        if (key_cnt_q == 2'd0) key_valid_d = 1'b0;
                        if (key_cnt_q == 2'd3) key_valid_d = 1'b1;
                    end else begin
                        blk_input_d[data_base +: 32] = InData;
                        data_cnt_d = data_cnt_q + 3'd1;
                        if (data_cnt_q == 3'd3) blk_inv_d = InInv;
                    end
                end
                // Decision uses registered counts, so it lands one cycle after the completing word.
                if ((data_cnt_q == 3'd4) && key_valid_q) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 4'd1;
                if (wait_cnt_q == LAT_LAST) begin
                    result_d  = BlkOutput;
                    out_cnt_d = '0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                OutValid = 1'b1;
                OutData  = result_q[out_base +: 32];
                OutLast  = (out_cnt_q == 2'd3);
                if (OutReady) begin
                    out_cnt_d = out_cnt_q + 2'd1;
                    if (out_cnt_q == 2'd3) begin
                        state_d    = ST_LOAD;
                        data_cnt_d = '0;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            data_cnt_q  <= '0;
            key_cnt_q   <= '0;
            key_valid_q <= 1'b0;
            wait_cnt_q  <= '0;
            out_cnt_q   <= '0;
            blk_input_q <= '0;
            blk_key_q   <= '0;
            blk_inv_q   <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            data_cnt_q  <= data_cnt_d;
            key_cnt_q   <= key_cnt_d;
            key_valid_q <= key_valid_d;
            wait_cnt_q  <= wait_cnt_d;
            out_cnt_q   <= out_cnt_d;
            blk_input_q <= blk_input_d;
            blk_key_q   <= blk_key_d;
            blk_inv_q   <= blk_inv_d;
            result_q    <= result_d;
        end
    end

endmodule

// File: tb/tb_aes_word_loader.sv
// Testbench for aes_word_loader with a reference-table AES core stand-in.
module tb_aes_word_loader;

    localparam logic [127:0] K_FIPS  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_aux = 1'b1;
    logic InValid = 1'b0, InIsKey = 1'b0, InInv = 1'b0, OutReady = 1'b1;
    logic [31:0] InData = '0;

    logic in_ready_a, blk_inv_a, out_valid_a, out_last_a, busy_a;
    logic in_ready_b, blk_inv_b, out_valid_b, out_last_b, busy_b;
    logic in_ready_c, blk_inv_c, out_valid_c, out_last_c, busy_c;
    logic [127:0] blk_input_a, blk_key_a, blk_output_a;
    logic [127:0] blk_input_b, blk_key_b, blk_output_b;
    logic [127:0] blk_input_c, blk_key_c, blk_output_c;
    logic [31:0] out_data_a, out_data_b, out_data_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Known-answer table for the FIPS-197 C.1 pair; anything else gets a simple mix.
    function automatic logic [127:0] core_model(input logic [127:0] din, input logic [127:0] key,
                                                input logic inv);
        if (!inv && key == K_FIPS && din == PT_FIPS) return CT_FIPS;
        if (inv && key == K_FIPS && din == CT_FIPS) return PT_FIPS;
        return din ^ key ^ {128{inv}};
    endfunction

    assign blk_output_a = core_model(blk_input_a, blk_key_a, blk_inv_a);
    assign blk_output_b = core_model(blk_input_b, blk_key_b, blk_inv_b);
    assign blk_output_c = core_model(blk_input_c, blk_key_c, blk_inv_c);

    aes_word_loader #(.LATENCY_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .InValid(InValid), .InReady(in_ready_a), .InData(InData),
        .InIsKey(InIsKey), .InInv(InInv), .BlkInput(blk_input_a), .BlkKey(blk_key_a),
        .BlkInv(blk_inv_a), .BlkOutput(blk_output_a), .OutValid(out_valid_a),
        .OutReady(OutReady), .OutData(out_data_a), .OutLast(out_last_a), .Busy(busy_a));

    aes_word_loader #(.LATENCY_CYCLES(1)) u_l1 (
        .clk(clk), .rst(rst_aux), .InValid(InValid), .InReady(in_ready_b), .InData(InData),
        .InIsKey(InIsKey), .InInv(InInv), .BlkInput(blk_input_b), .BlkKey(blk_key_b),
        .BlkInv(blk_inv_b), .BlkOutput(blk_output_b), .OutValid(out_valid_b),
        .OutReady(OutReady), .OutData(out_data_b), .OutLast(out_last_b), .Busy(busy_b));

    aes_word_loader #(.LATENCY_CYCLES(15)) u_l15 (
        .clk(clk), .rst(rst_aux), .InValid(InValid), .InReady(in_ready_c), .InData(InData),
        .InIsKey(InIsKey), .InInv(InInv), .BlkInput(blk_input_c), .BlkKey(blk_key_c),
        .BlkInv(blk_inv_c), .BlkOutput(blk_output_c), .OutValid(out_valid_c),
        .OutReady(OutReady), .OutData(out_data_c), .OutLast(out_last_c), .Busy(busy_c));

    typedef struct {
        logic [127:0] key;
        logic         reload;
        logic [127:0] din;
        logic         inv;
        logic [127:0] exp_out;
    } blk_vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] v, input int i);
        return v[(3 - i) * 32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted (bounded).
    task automatic send_word(input logic [31:0] d, input logic is_key, input logic inv);
        logic done;
        done = 1'b0;
        InValid = 1'b1; InData = d; InIsKey = is_key; InInv = inv;
        for (int t = 0; t < 50 && !done; t++) begin
            #1;
            if (in_ready_a) done = 1'b1;
            tick();
        end
        InValid = 1'b0; InIsKey = 1'b0; InInv = 1'b0;
        if (!done) check("send_word_timeout", 128'(done), 128'd1);
    endtask

    task automatic send_block(input logic [127:0] key, input logic reload,
                              input logic [127:0] din, input logic inv);
        if (reload)
            for (int i = 0; i < 4; i++) send_word(word_of(key, i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_word(word_of(din, i), 1'b0, inv);
    endtask

    task automatic wait_out_valid();
        for (int t = 0; t < 60 && !out_valid_a; t++) tick();
        check("wait_out_valid", 128'(out_valid_a), 128'd1);
    endtask

    // Drain four words with OutReady held high and check each one.
    task automatic drain(input string name, input logic [127:0] exp);
        OutReady = 1'b1;
        wait_out_valid();
        for (int k = 0; k < 4; k++) begin
            check({name, "_data"}, 128'(out_data_a), 128'(word_of(exp, k)));
            check({name, "_last"}, 128'(out_last_a), 128'(k == 3));
            tick();
        end
        check({name, "_valid_done"}, 128'(out_valid_a), 128'd0);
        check({name, "_busy_done"}, 128'(busy_a), 128'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        blk_vec_t vecs[3];
        int first_a, first_b, first_c, cnt_a, cnt_b, cnt_c, k;
        logic [127:0] got_a, got_b, got_c;

        vecs[0] = '{key: K_FIPS, reload: 1'b1, din: PT_FIPS, inv: 1'b0, exp_out: CT_FIPS};
        vecs[1] = '{key: K_FIPS, reload: 1'b0, din: CT_FIPS, inv: 1'b1, exp_out: PT_FIPS};
        vecs[2] = '{key: K_FIPS, reload: 1'b0,
                    din: 128'hffffffff00000000123456789abcdef0, inv: 1'b0,
                    exp_out: 128'hfffefdfc040506071a3d5c7396b1d0ff};

        // Reset state
        repeat (3) tick();
        check("rst_out_valid", 128'(out_valid_a), 128'd0);
        check("rst_out_data", 128'(out_data_a), 128'd0);
        check("rst_out_last", 128'(out_last_a), 128'd0);
        check("rst_busy", 128'(busy_a), 128'd0);
        check("rst_blk_input", blk_input_a, 128'd0);
        check("rst_blk_key", blk_key_a, 128'd0);
        check("rst_blk_inv", 128'(blk_inv_a), 128'd0);
        rst = 1'b0; rst_aux = 1'b0;
        #1;
        check("rst_in_ready", 128'(in_ready_a), 128'd1);
        tick();

        // Latency 1 / 2 / 15 run in lockstep on the same block
        OutReady = 1'b1;
        send_block(K_FIPS, 1'b1, PT_FIPS, 1'b0);
        first_a = -1; first_b = -1; first_c = -1;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        got_a = '0; got_b = '0; got_c = '0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (out_valid_a) begin
                if (first_a < 0) first_a = c;
                if (cnt_a < 4) got_a[(3 - cnt_a) * 32 +: 32] = out_data_a;
                cnt_a++;
            end
            if (out_valid_b) begin
                if (first_b < 0) first_b = c;
                if (cnt_b < 4) got_b[(3 - cnt_b) * 32 +: 32] = out_data_b;
                cnt_b++;
            end
            if (out_valid_c) begin
                if (first_c < 0) first_c = c;
                if (cnt_c < 4) got_c[(3 - cnt_c) * 32 +: 32] = out_data_c;
                cnt_c++;
            end
        end
        check("lat1_first_valid", 128'(first_b), 128'd2);
        check("lat2_first_valid", 128'(first_a), 128'd3);
        check("lat15_first_valid", 128'(first_c), 128'd16);
        check("lat1_result", got_b, CT_FIPS);
        check("lat2_result", got_a, CT_FIPS);
        check("lat15_result", got_c, CT_FIPS);
        check("lat1_words", 128'(cnt_b), 128'd4);
        check("lat15_words", 128'(cnt_c), 128'd4);
        rst_aux = 1'b1;

        // Table-driven blocks on the main instance
        for (int v = 0; v < 3; v++) begin
            send_block(vecs[v].key, vecs[v].reload, vecs[v].din, vecs[v].inv);
            tick();
            check($sformatf("vec%0d_busy", v), 128'(busy_a), 128'd1);
            drain($sformatf("vec%0d", v), vecs[v].exp_out);
            check($sformatf("vec%0d_blk_key", v), blk_key_a, vecs[v].key);
            check($sformatf("vec%0d_blk_input", v), blk_input_a, vecs[v].din);
            check($sformatf("vec%0d_blk_inv", v), 128'(blk_inv_a), 128'(vecs[v].inv));
        end

        // Output backpressure
        send_block(K_FIPS, 1'b0, PT_FIPS, 1'b0);
        OutReady = 1'b0;
        InIsKey = 1'b1;
        wait_out_valid();
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_data", 128'(out_data_a), 128'h69c4e0d8);
            check("bp_hold_last", 128'(out_last_a), 128'd0);
            check("bp_in_ready", 128'(in_ready_a), 128'd0);
            tick();
        end
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            OutReady = (c % 2 == 0);
            #1;
            if (out_valid_a) begin
                check("bp_in_ready_send", 128'(in_ready_a), 128'd0);
                if (OutReady) begin
                    check("bp_data", 128'(out_data_a), 128'(word_of(CT_FIPS, k)));
                    check("bp_last", 128'(out_last_a), 128'(k == 3));
                    k++;
                end
            end
            tick();
        end
        check("bp_word_count", 128'(k), 128'd4);
        check("bp_valid_done", 128'(out_valid_a), 128'd0);
        OutReady = 1'b1;
        InIsKey = 1'b0;

        // Data before key
        rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int i = 0; i < 4; i++) send_word(word_of(PT_FIPS, i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_word(word_of(K_FIPS, i), 1'b1, 1'b0);
        repeat (3) tick();
        check("dbk_busy_partial_key", 128'(busy_a), 128'd0);
        InValid = 1'b1; InIsKey = 1'b0; InData = 32'hdeadbeef;
        #1;
        check("dbk_5th_data_stall", 128'(in_ready_a), 128'd0);
        tick();
        InValid = 1'b0;
        send_word(word_of(K_FIPS, 3), 1'b1, 1'b0);
        check("dbk_busy_same_cycle", 128'(busy_a), 128'd0);
        tick();
        check("dbk_busy_next_cycle", 128'(busy_a), 128'd1);
        drain("dbk", CT_FIPS);

        // Reset during WAIT
        send_block(K_FIPS, 1'b0, PT_FIPS, 1'b0);
        tick();
        check("rw_in_wait", 128'({busy_a, out_valid_a}), 128'b10);
        rst = 1'b1;
        #1;
        check("rw_out_valid", 128'(out_valid_a), 128'd0);
        check("rw_busy", 128'(busy_a), 128'd0);
        tick();
        rst = 1'b0;

        // Reset during SEND with two words already delivered
        send_block(K_FIPS, 1'b1, PT_FIPS, 1'b0);
        OutReady = 1'b1;
        wait_out_valid();
        tick(); tick();
        OutReady = 1'b0;
        check("rs_pre_word2", 128'(out_data_a), 128'hd8cdb780);
        rst = 1'b1;
        #1;
        check("rs_out_valid", 128'(out_valid_a), 128'd0);
        check("rs_out_data", 128'(out_data_a), 128'd0);
        check("rs_out_last", 128'(out_last_a), 128'd0);
        check("rs_busy", 128'(busy_a), 128'd0);
        tick();
        rst = 1'b0;
        OutReady = 1'b1;
        for (int i = 0; i < 4; i++) send_word(word_of(PT_FIPS, i), 1'b0, 1'b0);
        k = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy_a || out_valid_a) k++;
            tick();
        end
        check("rs_no_key_stays_load", 128'(k), 128'd0);
        InValid = 1'b1; InIsKey = 1'b0;
        #1;
        check("rs_no_key_stall", 128'(in_ready_a), 128'd0);
        tick();
        InValid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_word_loader.md
Name: aes_word_loader

Overview:
Sequential front/back end for the combinational AES-128 encrypt/decrypt core. Accepts 32-bit words over a valid/ready stream, assembles a 128-bit key and a 128-bit data block, and presents both plus the direction flag to the core as stable registers. After a programmable settle time it captures the core's 128-bit result and streams it back out as four 32-bit words. The key is retained across blocks until it is reloaded.

Parameters:
LATENCY_CYCLES, 2, cycles the core inputs are held stable before the result is captured; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
InValid  input  1  input word valid
InReady  output  1  input word accepted when InValid && InReady
InData  input  32  input word
InIsKey  input  1  1 = key word, 0 = data word; qualified by InValid
InInv  input  1  direction; sampled with the 4th data word; 1 = decrypt
BlkInput  output  128  registered data block to core Input
BlkKey  output  128  registered key to core CipherKey
BlkInv  output  1  registered direction to core inv
BlkOutput  input  128  core Output
OutValid  output  1  output word valid
OutReady  input  1  output word consumed when OutValid && OutReady
OutData  output  32  output word
OutLast  output  1  high with the 4th output word
Busy  output  1  high when state != LOAD

Behaviour:
- Reset is asynchronous and active-high: state=LOAD; DataCnt=0; KeyCnt=0; KeyValid=0; WaitCnt=0; OutCnt=0; BlkInput, BlkKey, result register=0; BlkInv=0. Outputs after reset: OutValid=0, OutLast=0, OutData=0, Busy=0. Reset mid-block discards all partial data and the key.
- Word order is MSW first: word 0 -> bits [127:96], word 3 -> bits [31:0]. This applies to data, key and output.
- States: LOAD, WAIT, SEND.
- LOAD:
  - InReady = !(DataCnt==4 && !InIsKey), so key words are always accepted and a 5th data word is stalled.
  - An accepted data word writes BlkInput slot DataCnt and increments DataCnt. The 4th data word also latches InInv into BlkInv.
  - An accepted key word writes BlkKey slot KeyCnt and increments KeyCnt modulo 4. KeyValid is cleared on the 1st key word and set when the 4th key word is accepted.
  - Transition LOAD->WAIT when the registered DataCnt==4 && KeyValid==1. This is evaluated on registered values, so the earliest transition is the cycle after the completing word. WaitCnt is cleared on entry.
- WAIT:
  - InReady=0. BlkInput, BlkKey and BlkInv are held constant.
  - WaitCnt increments each cycle. When WaitCnt==LATENCY_CYCLES-1, BlkOutput is captured into the result register, OutCnt=0, and the state moves to SEND.
- SEND:
  - OutValid=1. OutData=result word OutCnt. OutLast=(OutCnt==3).
  - On OutValid && OutReady, OutCnt increments.
  - On the handshake of the 4th word: state=LOAD, DataCnt=0. BlkInput holds its value; KeyValid, KeyCnt and BlkKey are retained. OutValid deasserts the next cycle.
  - OutData and OutLast are stable while OutValid=1 && OutReady=0.
- Outside SEND: OutValid=0, OutLast=0, OutData=0.
- A partial key reload (KeyCnt 1..3) blocks the next block from starting until the 4th key word arrives.
- Throughput: 4 data-in cycles, 1 decision cycle, LATENCY_CYCLES wait cycles, then at least 4 out cycles.

Test Plan:
- Encrypt, FIPS-197 C.1 vector, real core attached, OutReady=1:
  - Stimulus: key words 00010203, 04050607, 08090a0b, 0c0d0e0f; data 00112233, 44556677, 8899aabb, ccddeeff with InInv=0.
  - Required: OutData 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; OutLast on the 4th word; Busy high from the cycle after the 4th data word.
- Decrypt with the retained key, no key reload:
  - Stimulus: data 69c4e0d8..70b4c55a with InInv=1.
  - Required: 00112233, 44556677, 8899aabb, ccddeeff.
- Data before key:
  - Stimulus: 4 data words then 3 key words.
  - Required: state stays LOAD and a 5th data word sees InReady=0. After the 4th key word, WAIT is entered the next cycle.
- Output backpressure:
  - Stimulus: OutReady=0 for 5 cycles in SEND, then toggle 1/0.
  - Required: OutData holds 69c4e0d8 until the first handshake; exactly 4 words are delivered; no new input is accepted until after the 4th.
- Reset mid-operation:
  - Stimulus: assert rst during WAIT, then during SEND with OutCnt=2.
  - Required: immediate OutValid=0, Busy=0, KeyValid=0. A following block without a key reload never leaves LOAD.
- LATENCY_CYCLES=1 vs 15:
  - Required: cycles from the 4th data word to first OutValid are 2 and 16 respectively, with identical results.
